// File: rtl/ctrl_msg_arbiter_pkg.sv
// Shared types and constants for the control-message arbiter: field widths,
// the packed message layout {dir,x,y,type,card,len} and FSM state encoding.
package ctrl_msg_arbiter_pkg;

   localparam int unsigned MOVE_DIR_W = 1;
   localparam int unsigned BLOCK_X_W  = 5;
   localparam int unsigned BLOCK_Y_W  = 3;
   localparam int unsigned MSG_TYPE_W = 4;
   localparam int unsigned CARD_W     = 6;
   localparam int unsigned SEL_LEN_W  = 3;
   localparam int unsigned CTRL_MSG_W = MOVE_DIR_W + BLOCK_X_W + BLOCK_Y_W
                                      + MSG_TYPE_W + CARD_W + SEL_LEN_W;
   localparam int unsigned TIMER_W    = 10;

   localparam logic [MSG_TYPE_W-1:0] MSG_HAND_DOWN = 4'd4;

   typedef struct packed {
      logic                  move_dir;
      logic [BLOCK_X_W-1:0]  block_x;
      logic [BLOCK_Y_W-1:0]  block_y;
      logic [MSG_TYPE_W-1:0] msg_type;
      logic [CARD_W-1:0]     card;
      logic [SEL_LEN_W-1:0]  sel_len;
   } ctrl_msg_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } state_e;

endpackage

// File: rtl/ctrl_msg_arbiter_if.sv
// Bundle of requester fields, the InterboardCommunication message port and
// the per-requester completion pulses. master = arbiter side, slave = the
// requesters plus the peer link.
interface ctrl_msg_arbiter_if #(
   parameter int unsigned NREQ = 4
);
   import ctrl_msg_arbiter_pkg::*;

   logic [NREQ-1:0]            req_en;
   logic [NREQ-1:0]            req_move_dir;
   logic [BLOCK_X_W*NREQ-1:0]  req_block_x;
   logic [BLOCK_Y_W*NREQ-1:0]  req_block_y;
   logic [MSG_TYPE_W*NREQ-1:0] req_msg_type;
   logic [CARD_W*NREQ-1:0]     req_card;
   logic [SEL_LEN_W*NREQ-1:0]  req_sel_len;
   logic                       inter_ready;

   logic                       ctrl_en;
   logic                       ctrl_move_dir;
   logic [BLOCK_X_W-1:0]       ctrl_block_x;
   logic [BLOCK_Y_W-1:0]       ctrl_block_y;
   logic [MSG_TYPE_W-1:0]      ctrl_msg_type;
   logic [CARD_W-1:0]          ctrl_card;
   logic [SEL_LEN_W-1:0]       ctrl_sel_len;
   logic [NREQ-1:0]            req_ack;
   logic [NREQ-1:0]            req_err;
   logic                       busy;

   modport master (
      input  req_en, req_move_dir, req_block_x, req_block_y, req_msg_type,
             req_card, req_sel_len, inter_ready,
      output ctrl_en, ctrl_move_dir, ctrl_block_x, ctrl_block_y, ctrl_msg_type,
             ctrl_card, ctrl_sel_len, req_ack, req_err, busy
   );

   modport slave (
      output req_en, req_move_dir, req_block_x, req_block_y, req_msg_type,
             req_card, req_sel_len, inter_ready,
      input  ctrl_en, ctrl_move_dir, ctrl_block_x, ctrl_block_y, ctrl_msg_type,
             ctrl_card, ctrl_sel_len, req_ack, req_err, busy
   );

endinterface

// File: rtl/ctrl_msg_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant of the first set request at or after ptr,
// wrapping to the lowest index.
module ctrl_msg_arbiter_rr_pick #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic             valid
);

   // Two passes instead of a modulo rotation: upper pass covers [ptr, NREQ-1],
   // the wrap pass only fires when nothing at or above ptr is requesting.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (!valid && req[j] && (j >= 32'(ptr))) begin
            grant[j] = 1'b1;
            valid    = 1'b1;
         end
      end
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (!valid && req[j]) begin
            grant[j] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ctrl_msg_arbiter.sv
// Shares the single GameControl -> InterboardCommunication message port among
// NREQ requesters: round-robin grant, one-cycle ctrl_en, inter_ready
// busy/done tracking with timeout, then a one-cycle ack or err to the winner.
module ctrl_msg_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               interboard_rst,
   ctrl_msg_arbiter_if.master bus
);
   import ctrl_msg_arbiter_pkg::*;

   localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e             state, state_nx;
   ctrl_msg_t          msg_q, msg_nx, sel_msg;
   logic [PTR_W-1:0]   grant_q, grant_nx, rr_ptr, rr_nx, sel_idx;
   logic [TIMER_W-1:0] timer, timer_nx, timer_inc;
   logic               en_q, en_nx, busy_q, busy_nx;
   logic               timed_out, finish;
   logic [NREQ-1:0]    ack_q, ack_nx, err_q, err_nx;
   logic [NREQ-1:0]    pick_req, pick_grant, done_vec;
   logic               pick_valid;

   // The requester being acked this cycle still holds req_en; hide it so it
   // is not granted a second time for the same message.
   assign pick_req = bus.req_en & ~(ack_q | err_q);

   ctrl_msg_arbiter_rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req   (pick_req),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .valid (pick_valid)
   );

   // Encode the one-hot pick and gather the winner's message fields.
   always_comb begin
      sel_msg = '0;
      sel_idx = '0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (pick_grant[j]) begin
            sel_idx          = PTR_W'(j);
            sel_msg.move_dir = bus.req_move_dir[j];
            sel_msg.block_x  = bus.req_block_x[BLOCK_X_W*j +: BLOCK_X_W];
            sel_msg.block_y  = bus.req_block_y[BLOCK_Y_W*j +: BLOCK_Y_W];
            sel_msg.msg_type = bus.req_msg_type[MSG_TYPE_W*j +: MSG_TYPE_W];
            sel_msg.card     = bus.req_card[CARD_W*j +: CARD_W];
            sel_msg.sel_len  = bus.req_sel_len[SEL_LEN_W*j +: SEL_LEN_W];
         end
      end
   end

   // One-hot form of the current grant index for the ack/err pulses.
   always_comb begin
      done_vec = '0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (grant_q == PTR_W'(j)) begin
            done_vec[j] = 1'b1;
         end
      end
   end

   // Next-state, next-output and bookkeeping for the message transaction.
   always_comb begin
      state_nx  = state;
      msg_nx    = msg_q;
      grant_nx  = grant_q;
      rr_nx     = rr_ptr;
      timer_nx  = timer;
      en_nx     = 1'b0;
      ack_nx    = '0;
      err_nx    = '0;
      finish    = 1'b0;
      timer_inc = timer + TIMER_W'(1);
      timed_out = (timer_inc == TIMER_W'(TIMEOUT));
      unique case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               msg_nx   = sel_msg;
               grant_nx = sel_idx;
               state_nx = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.inter_ready) begin
               en_nx    = 1'b1;
               timer_nx = '0;
               state_nx = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_BUSY: begin
            if (!bus.inter_ready) begin
               timer_nx = '0;
               state_nx = ST_WAIT_DONE;
            end else if (timed_out) begin
               finish = 1'b1;
               err_nx = done_vec;
            end else begin
               timer_nx = timer_inc;
            end
         end
         ST_WAIT_DONE: begin
            if (bus.inter_ready) begin
               finish = 1'b1;
               ack_nx = done_vec;
            end else if (timed_out) begin
               finish = 1'b1;
               err_nx = done_vec;
            end else begin
               timer_nx = timer_inc;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      if (finish) begin
         state_nx = ST_IDLE;
         msg_nx   = '0;
         timer_nx = '0;
         rr_nx    = (grant_q == PTR_W'(NREQ - 1)) ? '0 : grant_q + PTR_W'(1);
      end
      busy_nx = (state_nx != ST_IDLE);
   end

   // State and registered outputs; either reset source aborts silently.
   always_ff @(posedge clk) begin
      if (rst || interboard_rst) begin
         state   <= ST_IDLE;
         msg_q   <= '0;
         grant_q <= '0;
         rr_ptr  <= '0;
         timer   <= '0;
         en_q    <= 1'b0;
         ack_q   <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         msg_q   <= msg_nx;
         grant_q <= grant_nx;
         rr_ptr  <= rr_nx;
         timer   <= timer_nx;
         en_q    <= en_nx;
         ack_q   <= ack_nx;
         err_q   <= err_nx;
         busy_q  <= busy_nx;
      end
   end

   assign bus.ctrl_en       = en_q;
   assign bus.ctrl_move_dir = msg_q.move_dir;
   assign bus.ctrl_block_x  = msg_q.block_x;
   assign bus.ctrl_block_y  = msg_q.block_y;
   assign bus.ctrl_msg_type = msg_q.msg_type;
   assign bus.ctrl_card     = msg_q.card;
   assign bus.ctrl_sel_len  = msg_q.sel_len;
   assign bus.req_ack       = ack_q;
   assign bus.req_err       = err_q;
   assign bus.busy          = busy_q;

endmodule

// File: tb/tb_ctrl_msg_arbiter.sv
// Bench for ctrl_msg_arbiter: reset state, a round-robin vector table, directed
// multi-cycle sequences and randomized traffic against a transaction-level model.
module tb_ctrl_msg_arbiter;
   import ctrl_msg_arbiter_pkg::*;

   localparam int N = 4;
   localparam int T = 8;

   logic clk = 1'b0;
   logic rst;
   logic interboard_rst;

   ctrl_msg_arbiter_if #(.NREQ(N)) bus ();

   ctrl_msg_arbiter #(.NREQ(N), .TIMEOUT(T)) dut (
      .clk            (clk),
      .rst            (rst),
      .interboard_rst (interboard_rst),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   logic [N-1:0] rq;
   logic [N-1:0] acked;
   int           ptr;
   logic         f_dir [N];
   logic [4:0]   f_x   [N];
   logic [2:0]   f_y   [N];
   logic [3:0]   f_t   [N];
   logic [5:0]   f_c   [N];
   logic [2:0]   f_l   [N];

   typedef struct {
      logic [N-1:0] req;
      int           exp_w;
   } vec_t;
   vec_t tbl [9];

   function automatic logic [21:0] fmsg(int i);
      return {f_dir[i], f_x[i], f_y[i], f_t[i], f_c[i], f_l[i]};
   endfunction

   function automatic logic [31:0] obs();
      return {bus.ctrl_en, bus.req_ack, bus.req_err, bus.busy, bus.ctrl_move_dir,
              bus.ctrl_block_x, bus.ctrl_block_y, bus.ctrl_msg_type, bus.ctrl_card,
              bus.ctrl_sel_len};
   endfunction

   function automatic logic [31:0] expv(logic en, logic [N-1:0] ack, logic [N-1:0] err,
                                        logic bsy, logic [21:0] m);
      return {en, ack, err, bsy, m};
   endfunction

   // Round-robin rule: first requesting index at or after p, wrapping.
   function automatic int pick(logic [N-1:0] r, int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply();
      bus.req_en = rq;
      for (int i = 0; i < N; i++) begin
         bus.req_move_dir[i]       = f_dir[i];
         bus.req_block_x[5*i +: 5] = f_x[i];
         bus.req_block_y[3*i +: 3] = f_y[i];
         bus.req_msg_type[4*i +: 4] = f_t[i];
         bus.req_card[6*i +: 6]    = f_c[i];
         bus.req_sel_len[3*i +: 3] = f_l[i];
      end
   endtask

   task automatic new_fields(input int i);
      f_dir[i] = 1'($urandom);
      f_x[i]   = 5'($urandom);
      f_y[i]   = 3'($urandom);
      f_t[i]   = 4'($urandom);
      f_c[i]   = 6'($urandom);
      f_l[i]   = 3'($urandom);
   endtask

   task automatic quiesce(input string tag);
      rq = '0;
      acked = '0;
      apply();
      step();
      chk({tag, " idle"}, obs(), expv(1'b0, '0, '0, 1'b0, '0));
   endtask

   // One complete message: grant at the next edge, ISSUE stall cycles, then
   // b1 ready-high cycles before the peer goes busy and b2 busy cycles.
   task automatic txn(input int stall, input int b1, input int b2, input int w,
                      input bit drop, input string tag);
      logic [21:0]  m;
      logic [N-1:0] one;
      int           done_off;
      bit           e;
      m = fmsg(w);
      one = '0;
      one[w] = 1'b1;
      e = (b1 >= T) || (b2 >= T);
      done_off = (b1 >= T) ? T : (b1 + 1 + ((b2 >= T) ? T : b2 + 1));
      bus.inter_ready = (stall == 0);
      apply();
      step();
      chk({tag, " issue"}, obs(), expv(1'b0, '0, '0, 1'b1, m));
      rq = rq & ~acked;
      acked = '0;
      apply();
      for (int c = 1; c <= stall; c++) begin
         step();
         chk({tag, " stall"}, obs(), expv(1'b0, '0, '0, 1'b1, m));
         bus.inter_ready = (c == stall);
      end
      step();
      chk({tag, " ctrl_en"}, obs(), expv(1'b1, '0, '0, 1'b1, m));
      for (int c = 0; c < done_off; c++) begin
         bus.inter_ready = (c < b1) || (c >= b1 + 1 + b2);
         if (drop && c == 0) begin
            rq[w] = 1'b0;
            new_fields(w);
            apply();
         end
         step();
         if (c + 1 < done_off)
            chk({tag, " wait"}, obs(), expv(1'b0, '0, '0, 1'b1, m));
      end
      chk({tag, " done"}, obs(), expv(1'b0, e ? '0 : one, e ? one : '0, 1'b0, '0));
      ptr = (w + 1) % N;
      acked = one;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] eff;
      int           w, ri;

      tbl[0] = '{4'b0001, 0};
      tbl[1] = '{4'b0001, 0};
      tbl[2] = '{4'b1111, 1};
      tbl[3] = '{4'b1001, 3};
      tbl[4] = '{4'b1010, 1};
      tbl[5] = '{4'b0100, 2};
      tbl[6] = '{4'b0111, 0};
      tbl[7] = '{4'b1000, 3};
      tbl[8] = '{4'b0110, 1};

      for (int i = 0; i < N; i++) begin
         f_dir[i] = 1'(i);
         f_x[i]   = 5'(3 + 7 * i);
         f_y[i]   = 3'(i);
         f_t[i]   = 4'(i + 1);
         f_c[i]   = 6'(10 + i);
         f_l[i]   = 3'(7 - i);
      end
      rq = '0;
      acked = '0;
      ptr = 0;
      rst = 1'b1;
      interboard_rst = 1'b0;
      bus.inter_ready = 1'b0;
      apply();
      repeat (3) step();
      chk("reset", obs(), expv(1'b0, '0, '0, 1'b0, '0));
      rst = 1'b0;
      step();

      // contention: held 1011 -> 0,1,3,0
      rq = 4'b1011;
      txn(0, 1, 2, 0, 1'b0, "cont0");
      acked = '0;
      txn(0, 1, 2, 1, 1'b0, "cont1");
      acked = '0;
      txn(0, 1, 2, 3, 1'b0, "cont3");
      acked = '0;
      txn(0, 1, 2, 0, 1'b0, "cont0b");
      quiesce("cont");

      for (int r = 0; r < 9; r++) begin
         rq = tbl[r].req;
         txn(0, 1, 2, tbl[r].exp_w, 1'b0, $sformatf("tbl%0d", r));
         quiesce("tbl");
      end

      // single request, HAND_DOWN card 17, ready drops 3 cycles
      f_t[1] = MSG_HAND_DOWN;
      f_c[1] = 6'd17;
      rq = 4'b0010;
      txn(0, 1, 3, 1, 1'b0, "single");
      quiesce("single");

      rq = 4'b0001;
      txn(50, 1, 2, 0, 1'b0, "stall50");
      quiesce("stall50");

      rq = 4'b0100;
      txn(0, 20, 0, 2, 1'b0, "timeout");
      quiesce("timeout");

      rq = 4'b0001;
      txn(0, 2, 2, 0, 1'b1, "drop");
      quiesce("drop");

      // interboard reset in WAIT_DONE
      rq = 4'b0010;
      txn(0, 1, 1, 1, 1'b0, "pre_rst");
      quiesce("pre_rst");
      rq = 4'b1000;
      bus.inter_ready = 1'b1;
      apply();
      step();
      step();
      bus.inter_ready = 1'b0;
      step();
      step();
      chk("wait_done", obs(), expv(1'b0, '0, '0, 1'b1, fmsg(3)));
      interboard_rst = 1'b1;
      step();
      chk("ib_rst", obs(), expv(1'b0, '0, '0, 1'b0, '0));
      interboard_rst = 1'b0;
      rq = '0;
      apply();
      step();
      chk("post_rst0", obs(), expv(1'b0, '0, '0, 1'b0, '0));
      step();
      chk("post_rst1", obs(), expv(1'b0, '0, '0, 1'b0, '0));
      ptr = 0;
      rq = 4'b0110;
      txn(0, 1, 1, 1, 1'b0, "rst_ptr");
      quiesce("rst_ptr");
      rq = 4'b0100;
      txn(0, 1, 1, 2, 1'b0, "rst_idx2");
      quiesce("rst_idx2");

      // randomized traffic
      for (int it = 0; it < 150; it++) begin
         for (int i = 0; i < N; i++) begin
            if (!rq[i] && !acked[i] && $urandom_range(0, 2) == 0) begin
               rq[i] = 1'b1;
               new_fields(i);
            end
         end
         eff = rq & ~acked;
         if (eff == '0) begin
            apply();
            step();
            chk("rnd noregrant", obs(), expv(1'b0, '0, '0, 1'b0, '0));
            rq = rq & ~acked;
            acked = '0;
            ri = int'($urandom_range(0, N - 1));
            if (!rq[ri]) new_fields(ri);
            rq[ri] = 1'b1;
            eff = rq;
         end
         w = pick(eff, ptr);
         txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
             int'($urandom_range(0, 9)), w, ($urandom_range(0, 4) == 0),
             $sformatf("rnd%0d", it));
      end
      quiesce("end");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
